// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings, FSM states and request legality check for the load/store unit
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } lsu_state_e;

   // Requests that are answered with resp_err and never touch memory.
   function automatic logic req_is_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic bad_f3;
      logic misaligned;
      bad_f3     = we ? (f3 > F3_W) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
      misaligned = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
      return bad_f3 || misaligned;
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - little-endian lane extraction/extension for loads and lane merge for sub-word stores
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merged_o
);

   logic [4:0]  shamt;
   logic [15:0] lane;
   logic [31:0] mask;
   logic [31:0] ins;

   assign shamt = {offset_i, 3'b000};
   assign lane  = 16'(word_i >> shamt);
   assign ins   = wdata_i << shamt;

   always_comb begin
      load_o = word_i;
      case (funct3_i)
         F3_B:    load_o = {{24{lane[7]}}, lane[7:0]};
         F3_BU:   load_o = {24'b0, lane[7:0]};
         F3_H:    load_o = {{16{lane[15]}}, lane[15:0]};
         F3_HU:   load_o = {16'b0, lane[15:0]};
         default: load_o = word_i;
      endcase
   end

   // Lanes outside the mask keep the read word bit-exactly.
   always_comb begin
      mask = 32'hFFFF_FFFF;
      case (funct3_i[1:0])
         2'b00:   mask = 32'h0000_00FF << shamt;
         2'b01:   mask = 32'h0000_FFFF << shamt;
         default: mask = 32'hFFFF_FFFF;
      endcase
   end

   assign merged_o = (word_i & ~mask) | (ins & mask);

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I byte-addressed loads/stores onto a word-indexed memory, RMW for sb/sh
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_we
);

   lsu_state_e        state_q;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [1:0]        off_q;
   logic [DATA_W-1:0] wdata_q;
   logic              resp_valid_q;
   logic              resp_err_q;
   logic [DATA_W-1:0] resp_rdata_q;
   logic [ADDR_W-1:0] mem_rd_addr_q;
   logic [ADDR_W-1:0] mem_wr_addr_q;
   logic [DATA_W-1:0] mem_wr_data_q;
   logic [31:0]       load_w;
   logic [31:0]       merged_w;

   lsu_byte_lane u_lane (
      .funct3_i (funct3_q),
      .offset_i (off_q),
      .word_i   (mem_rd_data),
      .wdata_i  (wdata_q),
      .load_o   (load_w),
      .merged_o (merged_w)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         we_q          <= 1'b0;
         funct3_q      <= 3'b000;
         off_q         <= 2'b00;
         wdata_q       <= '0;
         resp_valid_q  <= 1'b0;
         resp_err_q    <= 1'b0;
         resp_rdata_q  <= '0;
         mem_rd_addr_q <= '0;
         mem_wr_addr_q <= '0;
         mem_wr_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  off_q    <= req_addr[1:0];
                  wdata_q  <= req_wdata;
                  if (req_is_err(req_we, req_funct3, req_addr[1:0])) begin
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                     state_q      <= RESP;
                  end else if (req_we && req_funct3 == F3_W) begin
                     // Full-word stores need no read of the old word.
                     mem_wr_addr_q <= req_addr >> 2;
                     mem_wr_data_q <= req_wdata;
                     state_q       <= WRITE;
                  end else begin
                     mem_rd_addr_q <= req_addr >> 2;
                     state_q       <= READ;
                  end
               end
            end
            READ: begin
               if (we_q) begin
                  mem_wr_addr_q <= mem_rd_addr_q;
                  mem_wr_data_q <= merged_w;
                  state_q       <= WRITE;
               end else begin
                  resp_rdata_q <= load_w;
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= RESP;
               end
            end
            WRITE: begin
               resp_rdata_q <= '0;
               resp_err_q   <= 1'b0;
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            RESP: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign resp_valid  = resp_valid_q;
   assign resp_err    = resp_err_q;
   assign resp_rdata  = resp_rdata_q;
   assign mem_rd_addr = mem_rd_addr_q;
   assign mem_wr_addr = mem_wr_addr_q;
   assign mem_wr_data = mem_wr_data_q;
   // Gated by rst_n so a write caught by reset never strobes.
   assign mem_we      = (state_q == WRITE) && rst_n;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a byte-level memory model
module tb_load_store_unit;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          lat;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wexp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_rd_addr;
   logic [31:0] mem_rd_data;
   logic [31:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic        mem_we;

   logic [31:0] dmem [64];
   logic [31:0] ref_mem [64];
   bit          booted = 1'b0;
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          resp_pulses = 0;
   int          wr_pulses = 0;
   logic [31:0] last_rdata = 32'h0;
   logic        last_err = 1'b0;
   logic [31:0] last_wr_addr = 32'h0;
   logic [31:0] last_wr_data = 32'h0;
   exp_t        rq[$];
   wexp_t       wq[$];

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .mem_we      (mem_we)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int i);
      if (i == 5) return 32'h8899_AABB;
      return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'h5A5A_0000;
   endfunction

   assign mem_rd_data = dmem[mem_rd_addr[5:0]];

   always @(posedge clk) begin
      if (!booted) begin
         for (int i = 0; i < 64; i++) dmem[i] <= init_word(i);
      end else if (mem_we) begin
         dmem[mem_wr_addr[5:0]] <= mem_wr_data;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s", name);
   endtask

   // Reference: memory as bytes, sizes and sign rules straight from the ISA.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output exp_t e, output bit wr,
                        output logic [31:0] wa, output logic [31:0] wdw);
      int          size;
      int          idx;
      int          off;
      bit          illegal;
      logic [31:0] val;
      size    = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
      illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      idx     = int'((addr / 4) % 64);
      off     = int'(addr % 4);
      e.rdata = 32'h0;
      e.err   = 1'b0;
      e.acc   = 0;
      e.lat   = 0;
      wr      = 1'b0;
      wa      = 32'h0;
      wdw     = 32'h0;
      if (illegal || (off % size) != 0) begin
         e.err = 1'b1;
         e.lat = 1;
      end else if (!we) begin
         val = 32'h0;
         for (int i = 0; i < size; i++) val[8*i +: 8] = ref_mem[idx][8*(off+i) +: 8];
         if (!f3[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
         e.rdata = val;
         e.lat   = 2;
      end else begin
         for (int i = 0; i < size; i++) ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
         wr    = 1'b1;
         wa    = addr / 4;
         wdw   = ref_mem[idx];
         e.lat = (size == 4) ? 2 : 3;
      end
   endtask

   always @(negedge clk) begin
      if (resp_valid) begin
         resp_pulses++;
         last_rdata = resp_rdata;
         last_err   = resp_err;
         if (rq.size() == 0) begin
            flag("unexpected resp_valid");
         end else begin
            exp_t e;
            e = rq.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("resp latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
      if (mem_we) begin
         wr_pulses++;
         last_wr_addr = mem_wr_addr;
         last_wr_data = mem_wr_data;
         if (wq.size() == 0) begin
            flag("unexpected mem_we");
         end else begin
            wexp_t w;
            w = wq.pop_front();
            chk("mem_wr_addr", mem_wr_addr, w.addr);
            chk("mem_wr_data", mem_wr_data, w.data);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accept edge with req_valid still high.
   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track);
      exp_t        e;
      bit          wr;
      logic [31:0] wa;
      logic [31:0] wdw;
      int          n;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      req_valid  = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!req_ready) flag("req_ready timeout");
      @(posedge clk);
      if (track) begin
         model(we, f3, addr, wd, e, wr, wa, wdw);
         e.acc = cyc;
         rq.push_back(e);
         if (wr) wq.push_back('{addr: wa, data: wdw});
      end
      #1;
   endtask

   task automatic drain();
      int n;
      req_valid = 1'b0;
      n = 0;
      while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (rq.size() != 0 || wq.size() != 0) begin
         flag("drain timeout");
         rq.delete();
         wq.delete();
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int w0;
      int r0;
      logic [2:0]  f3;
      logic [31:0] a;
      logic        we;
      logic [2:0]  ld_f3 [5];
      ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

      repeat (3) @(posedge clk);
      #1;
      chk("reset req_ready", 32'(req_ready), 32'h1);
      chk("reset resp_valid", 32'(resp_valid), 32'h0);
      chk("reset resp_err", 32'(resp_err), 32'h0);
      chk("reset mem_we", 32'(mem_we), 32'h0);
      chk("reset resp_rdata", resp_rdata, 32'h0);
      chk("reset mem_rd_addr", mem_rd_addr, 32'h0);
      chk("reset mem_wr_addr", mem_wr_addr, 32'h0);
      chk("reset mem_wr_data", mem_wr_data, 32'h0);
      booted = 1'b1;
      rst_n  = 1'b1;
      @(posedge clk);
      #1;
      chk("ready after reset", 32'(req_ready), 32'h1);

      w0 = wr_pulses;
      send(1'b0, 3'd0, 32'h15, 32'h0, 1'b1); drain();
      chk("lb 0x15", last_rdata, 32'hFFFF_FFAA);
      chk("lb 0x15 err", 32'(last_err), 32'h0);
      send(1'b0, 3'd5, 32'h16, 32'h0, 1'b1); drain();
      chk("lhu 0x16", last_rdata, 32'h0000_8899);
      send(1'b0, 3'd1, 32'h16, 32'h0, 1'b1); drain();
      chk("lh 0x16", last_rdata, 32'hFFFF_8899);
      send(1'b0, 3'd2, 32'h14, 32'h0, 1'b1); drain();
      chk("lw 0x14", last_rdata, 32'h8899_AABB);
      chk("loads no mem_we", 32'(wr_pulses - w0), 32'h0);

      w0 = wr_pulses;
      send(1'b1, 3'd0, 32'h17, 32'h1234_56CC, 1'b1); drain();
      chk("sb mem_we pulses", 32'(wr_pulses - w0), 32'h1);
      chk("sb mem_wr_addr", last_wr_addr, 32'h5);
      chk("sb mem_wr_data", last_wr_data, 32'hCC99_AABB);
      send(1'b0, 3'd2, 32'h14, 32'h0, 1'b1); drain();
      chk("lw after sb", last_rdata, 32'hCC99_AABB);

      w0 = wr_pulses;
      send(1'b0, 3'd2, 32'h22, 32'h0, 1'b1); drain();
      chk("lw 0x22 err", 32'(last_err), 32'h1);
      chk("lw 0x22 rdata", last_rdata, 32'h0);
      send(1'b1, 3'd1, 32'h21, 32'hBEEF, 1'b1); drain();
      chk("sh 0x21 err", 32'(last_err), 32'h1);
      send(1'b0, 3'd7, 32'h20, 32'h0, 1'b1); drain();
      chk("load f3=111 err", 32'(last_err), 32'h1);
      chk("errors no mem_we", 32'(wr_pulses - w0), 32'h0);

      w0 = wr_pulses;
      r0 = resp_pulses;
      send(1'b1, 3'd0, 32'h29, 32'h0000_00FF, 1'b0);
      req_valid = 1'b0;
      rst_n     = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready after sb reset", 32'(req_ready), 32'h1);
      chk("sb reset word 10", dmem[10], ref_mem[10]);

      send(1'b1, 3'd2, 32'h2C, 32'hDEAD_BEEF, 1'b0);
      req_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("mem_we gated in reset", 32'(mem_we), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready after sw reset", 32'(req_ready), 32'h1);
      chk("sw reset word 11", dmem[11], ref_mem[11]);
      chk("reset no mem_we", 32'(wr_pulses - w0), 32'h0);
      chk("reset no resp", 32'(resp_pulses - r0), 32'h0);

      w0 = wr_pulses;
      r0 = resp_pulses;
      send(1'b1, 3'd2, 32'h30, 32'h1111_1111, 1'b1);
      send(1'b1, 3'd2, 32'h34, 32'h2222_2222, 1'b1);
      send(1'b1, 3'd2, 32'h38, 32'h3333_3333, 1'b1);
      drain();
      chk("b2b mem_we pulses", 32'(wr_pulses - w0), 32'h3);
      chk("b2b resp pulses", 32'(resp_pulses - r0), 32'h3);

      for (int k = 0; k < 300; k++) begin
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
         else if (we) f3 = 3'($urandom_range(0, 2));
         else f3 = ld_f3[$urandom_range(0, 4)];
         if ($urandom_range(0, 7) == 0) a = $urandom;
         else a = 32'($urandom_range(0, 255));
         send(we, f3, a, $urandom, 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            req_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
      end
      drain();
      for (int i = 0; i < 64; i++) chk("final memory", dmem[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory (register_file) and is driven by the CPU execute stage.
- Converts RV32I byte-addressed loads and stores (lb/lh/lw/lbu/lhu/sb/sh/sw) into word-index memory accesses.
- Sub-word stores are done as read-modify-write.
- Loads return sign- or zero-extended data.
- Misaligned accesses and illegal funct3 values get an error response, with no memory write.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and word-index width of the mem_* addresses.
- DATA_W, 32, data width; fixed at 32 (other values unsupported).

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and accepting.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 (size/sign).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal funct3; valid with resp_valid.
- mem_rd_addr  output  32  word index (byte address >> 2).
- mem_rd_data  input  32  memory read data; combinational from mem_rd_addr.
- mem_wr_addr  output  32  word index for the write.
- mem_wr_data  output  32  full merged word.
- mem_we  output  1  write strobe.

Behaviour:
- Reset: synchronous, active-low. When rst_n is low at a clk edge:
  - state goes to IDLE.
  - resp_valid, resp_err, mem_we go to 0.
  - resp_rdata, mem_rd_addr, mem_wr_addr, mem_wr_data go to 0.
- Out of reset, req_ready=1.
- mem_we = (state==WRITE) && rst_n. It is gated combinationally, so an abandoned write never strobes while rst_n is low.
- States: IDLE, READ, WRITE, RESP. req_ready = (state==IDLE).
- IDLE:
  - On req_valid, the request is accepted and req_addr/funct3/wdata/we are captured.
  - Error request (see Error below): go to RESP with resp_err=1, no memory access.
  - sw: go to WRITE; mem_wr_data=req_wdata, mem_wr_addr=addr>>2.
  - Any other request: mem_rd_addr<=addr>>2, go to READ.
- READ:
  - mem_rd_data is sampled at the end of this cycle.
  - Load: extract lane and extend into resp_rdata, go to RESP.
  - sb/sh: merge the new bytes into the read word, then go to WRITE.
- WRITE: mem_we high for exactly one cycle, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. req_ready is asserted again the following cycle; there is no back-to-back acceptance in RESP.
- Latency from the accept edge to the resp_valid cycle:
  - load: 2 cycles.
  - sb/sh: 3 cycles.
  - sw: 2 cycles.
  - error: 1 cycle.
- Byte lanes are little-endian; offset = addr[1:0].
  - Byte accesses use lane offset.
  - Halfword accesses use lanes {offset+1, offset}.
- Load extension:
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw takes the word as-is.
- Merge: only the addressed lanes are replaced; all other lanes keep the read value bit-exactly.
- Error cases:
  - halfword with addr[0]=1.
  - word with addr[1:0]!=0.
  - load funct3 in {011,110,111}.
  - store funct3 > 010.
- req_valid while not IDLE is ignored; the requester must hold its request until req_ready.
- Address wrap: the word index is the plain shift of the byte address, with no bounds check.
- Reset mid-operation: the operation is abandoned, no response is issued, and no write occurs at or after the reset edge.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - state encoding: IDLE, READ, WRITE, RESP.
- Sub-module lsu_byte_lane is purely combinational. It performs load extraction/extension and store merge from (funct3, offset, word, wdata). It is instantiated once.

Test Plan:
- Memory word 5 = 0x8899AABB. lb at addr 0x15 -> resp_rdata=0xFFFFFFAA, resp_err=0, resp_valid 2 cycles after accept, mem_we never high.
- Same word. lhu at 0x16 -> 0x00008899. lh at 0x16 -> 0xFFFF8899. lw at 0x14 -> 0x8899AABB.
- sb 0x123456CC at 0x17 into word 0x8899AABB -> single mem_we pulse, mem_wr_addr=5, mem_wr_data=0xCC99AABB. Subsequent lw at 0x14 returns 0xCC99AABB.
- Misaligned and illegal requests:
  - lw at 0x22 -> resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept.
  - sh at 0x21 -> resp_err=1, no mem_we.
  - funct3=111 load -> resp_err=1.
- Reset during a sb: rst_n low in READ -> no mem_we at any point, no resp_valid, memory unchanged. Next cycle after release: req_ready=1.
- Back-to-back: req_valid held high across 3 sw requests -> each accepted only when req_ready=1. Exactly 3 mem_we pulses and 3 resp_valid pulses, in order.
